// File: rtl/serial_slave_port.sv
// Slave endpoint of the serial system bus: deserialises an address (and write data), drives a
// word-wide local memory, serialises read data back, and aborts stalled transfers on timeout.
module serial_slave_port #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  wr_bus,
    input  logic                  master_valid,
    output logic                  slave_ready,
    output logic                  rd_bus,
    output logic                  slave_valid,
    input  logic                  master_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int unsigned MaxW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CntW  = $clog2(MaxW + 1);
    localparam int unsigned IdleW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StWrite,
        StRreq,
        StRwait,
        StRdata
    } state_e;

    state_e                state_q;
    logic [CntW-1:0]       bit_cnt_q;
    logic [IdleW-1:0]      idle_cnt_q;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  timeout_err_q;

    logic in_beat;
    logic out_beat;
    logic stall_phase;
    logic last_addr;
    logic last_data;
    logic timed_out;

    assign slave_ready = (state_q == StIdle) || (state_q == StAddr) || (state_q == StWdata);
    assign slave_valid = (state_q == StRdata);
    assign rd_bus      = slave_valid & rdata_q[DATA_WIDTH-1];
    assign mem_we      = (state_q == StWrite);
    assign mem_re      = (state_q == StRreq);
    assign busy        = (state_q != StIdle);
    assign timeout_err = timeout_err_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;

    assign in_beat     = master_valid & slave_ready;
    assign out_beat    = slave_valid & master_ready;
    assign stall_phase = (state_q == StAddr) || (state_q == StWdata) || (state_q == StRdata);
    assign last_addr   = (bit_cnt_q == CntW'(ADDR_WIDTH - 1));
    assign last_data   = (bit_cnt_q == CntW'(DATA_WIDTH - 1));
    // Abort on the stall cycle that would bring the idle count up to TIMEOUT.
    assign timed_out   = (TIMEOUT != 0) && stall_phase && !in_beat && !out_beat &&
                         (idle_cnt_q == IdleW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            mode_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            if (timed_out) begin
                state_q       <= StIdle;
                bit_cnt_q     <= '0;
                idle_cnt_q    <= '0;
                timeout_err_q <= 1'b1;
            end else begin
                // Non-stalling states and every handshake keep the idle count at zero.
                if (in_beat || out_beat || !stall_phase || TIMEOUT == 0) begin
                    idle_cnt_q <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + IdleW'(1);
                end

                unique case (state_q)
                    StIdle: begin
                        if (in_beat) begin
                            mode_q <= mode;
                            addr_q <= ADDR_WIDTH'(wr_bus);
                            if (ADDR_WIDTH == 1) begin
                                bit_cnt_q <= '0;
                                state_q   <= mode ? StWdata : StRreq;
                            end else begin
                                bit_cnt_q <= CntW'(1);
                                state_q   <= StAddr;
                            end
                        end
                    end
                    StAddr: begin
                        if (in_beat) begin
                            addr_q <= (addr_q << 1) | ADDR_WIDTH'(wr_bus);
                            if (last_addr) begin
                                bit_cnt_q <= '0;
                                state_q   <= mode_q ? StWdata : StRreq;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CntW'(1);
                            end
                        end
                    end
                    StWdata: begin
                        if (in_beat) begin
                            wdata_q <= (wdata_q << 1) | DATA_WIDTH'(wr_bus);
                            if (last_data) begin
                                bit_cnt_q <= '0;
                                state_q   <= StWrite;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CntW'(1);
                            end
                        end
                    end
                    StWrite: state_q <= StIdle;
                    StRreq:  state_q <= StRwait;
                    StRwait: begin
                        rdata_q <= mem_rdata;
                        state_q <= StRdata;
                    end
                    StRdata: begin
                        if (out_beat) begin
                            rdata_q <= rdata_q << 1;
                            if (last_data) begin
                                bit_cnt_q <= '0;
                                state_q   <= StIdle;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CntW'(1);
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_slave_port.sv
// Scoreboard bench for serial_slave_port: stimulus pushes expected memory strobes, read bits
// and timeout pulses; a negedge monitor pops and compares them as the DUT produces them.
module tb_serial_slave_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        wr_bus;
    logic        master_valid;
    logic        slave_ready;
    logic        rd_bus;
    logic        slave_valid;
    logic        master_ready;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    serial_slave_port #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (8),
        .TIMEOUT    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .wr_bus       (wr_bus),
        .master_valid (master_valid),
        .slave_ready  (slave_ready),
        .rd_bus       (rd_bus),
        .slave_valid  (slave_valid),
        .master_ready (master_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    // Local memory model: registered read, one cycle after mem_re.
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        if (rst) begin
            mem[12'h00F] <= 8'h96;
            mem_rdata    <= 8'h00;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum logic [2:0] {EvWe, EvRe, EvRise, EvBit, EvTo} ev_e;
    typedef struct {
        ev_e         kind;
        logic [11:0] addr;
        logic [7:0]  data;
        int          cyc;
        bit          last;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad = 0;
    int  bits_seen = 0;
    bit  prev_sv = 1'b0;
    bit  idle_chk = 1'b0;
    bit  ready_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push_ev(input ev_e k, input logic [11:0] a, input logic [7:0] d,
                                    input int c, input bit last);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        e.last = last;
        q.push_back(e);
    endfunction

    task automatic pop_ev(input ev_e k, input string name, output ev_t e, output bit ok);
        ok = 1'b0;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL %s: DUT event kind %0d with nothing expected (cycle %0d)", name, k, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != k) begin
                bad++;
                $display("FAIL %s: got event kind %0d, required kind %0d (cycle %0d)",
                         name, k, e.kind, cyc);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    initial begin : monitor
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_sv   = 1'b0;
                idle_chk  = 1'b0;
                ready_chk = 1'b0;
            end else begin
                if (idle_chk) begin
                    chk("busy_after_last_bit", busy, 0);
                    chk("valid_after_last_bit", slave_valid, 0);
                    idle_chk = 1'b0;
                end
                if (ready_chk) begin
                    chk("ready_after_write", slave_ready, 1);
                    ready_chk = 1'b0;
                end
                if (mem_we) begin
                    pop_ev(EvWe, "mem_we", e, ok);
                    if (ok) begin
                        chk("we_addr", mem_addr, e.addr);
                        chk("we_data", mem_wdata, e.data);
                        chk("we_cycle", cyc, e.cyc);
                        chk("we_ready_low", slave_ready, 0);
                        ready_chk = 1'b1;
                    end
                end
                if (mem_re) begin
                    pop_ev(EvRe, "mem_re", e, ok);
                    if (ok) begin
                        chk("re_addr", mem_addr, e.addr);
                        chk("re_cycle", cyc, e.cyc);
                    end
                end
                if (slave_valid && !prev_sv) begin
                    pop_ev(EvRise, "valid_rise", e, ok);
                    if (ok) chk("valid_rise_cycle", cyc, e.cyc);
                end
                if (slave_valid && master_ready) begin
                    pop_ev(EvBit, "rd_bit", e, ok);
                    bits_seen++;
                    if (ok) begin
                        chk("rd_bit_value", rd_bus, e.data[0]);
                        if (e.last) idle_chk = 1'b1;
                    end
                end else if (slave_valid && q.size() > 0 && q[0].kind == EvBit) begin
                    chk("rd_bit_held", rd_bus, q[0].data[0]);
                end
                if (timeout_err) begin
                    pop_ev(EvTo, "timeout_err", e, ok);
                    if (ok) begin
                        chk("timeout_cycle", cyc, e.cyc);
                        chk("timeout_busy", busy, 0);
                        chk("timeout_ready", slave_ready, 1);
                    end
                end
                prev_sv = slave_valid;
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends nbits of val MSB first; last_cyc is the cycle in which the final beat completes.
    task automatic send_bits(input logic [31:0] val, input int nbits, input logic m_first,
                             input logic m_rest, input int gapmax, output int last_cyc);
        logic [31:0] v;
        v = val;
        for (int i = nbits - 1; i >= 0; i--) begin
            master_valid = 1'b1;
            wr_bus       = v[i];
            mode         = (i == nbits - 1) ? m_first : m_rest;
            last_cyc     = cyc;
            @(posedge clk);
            #1;
            master_valid = 1'b0;
            wr_bus       = 1'b0;
            if (gapmax > 0 && i > 0) idle_cycles(1 + (i % gapmax));
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d, input logic m_first,
                            input logic m_rest, input int gapmax);
        int c;
        send_bits({12'h000, a, d}, 20, m_first, m_rest, gapmax, c);
        push_ev(EvWe, a, d, c + 1, 1'b0);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [7:0] d, input bit toggle,
                           input int n);
        int c;
        int base;
        int g;
        send_bits({20'h00000, a}, 12, 1'b0, 1'b0, 0, c);
        push_ev(EvRe, a, 8'h00, c + 1, 1'b0);
        push_ev(EvRise, 12'h000, 8'h00, c + 3, 1'b0);
        for (int i = 0; i < n; i++) begin
            push_ev(EvBit, 12'h000, {7'h00, d[7 - i]}, 0, i == 7);
        end
        base = bits_seen;
        g = 0;
        master_ready = 1'b1;
        while (bits_seen < base + n && g < 100) begin
            @(posedge clk);
            #1;
            if (toggle) master_ready = ~master_ready;
            g++;
        end
        chk("read_bits_done", bits_seen - base, n);
        master_ready = 1'b0;
    endtask

    initial begin : stimulus
        int c;
        rst          = 1'b1;
        mode         = 1'b0;
        wr_bus       = 1'b0;
        master_valid = 1'b0;
        master_ready = 1'b0;
        idle_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_slave_ready", slave_ready, 1);
        chk("reset_slave_valid", slave_valid, 0);
        chk("reset_rd_bus", rd_bus, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_re", mem_re, 0);
        chk("reset_busy", busy, 0);
        chk("reset_timeout_err", timeout_err, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        #1;

        do_write(12'h5A5, 8'hC3, 1'b1, 1'b1, 0);
        idle_cycles(3);
        do_read(12'h00F, 8'h96, 1'b1, 8);
        idle_cycles(3);
        do_write(12'h5A5, 8'hC3, 1'b1, 1'b1, 3);
        idle_cycles(3);

        // Five address beats then silence: 32 stalled cycles, then the pulse.
        send_bits(32'h16, 5, 1'b1, 1'b1, 0, c);
        push_ev(EvTo, 12'h000, 8'h00, c + 33, 1'b0);
        idle_cycles(40);
        do_write(12'h7E1, 8'hA5, 1'b1, 1'b1, 0);
        idle_cycles(3);

        do_read(12'h5A5, 8'hC3, 1'b0, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midread_rst_valid", slave_valid, 0);
        chk("midread_rst_busy", busy, 0);
        chk("midread_rst_ready", slave_ready, 1);
        chk("midread_rst_timeout", timeout_err, 0);
        @(posedge clk);
        #1;
        do_write(12'h123, 8'h5E, 1'b1, 1'b1, 0);
        idle_cycles(3);
        do_read(12'h123, 8'h5E, 1'b0, 8);
        idle_cycles(3);

        do_write(12'h0AB, 8'h3C, 1'b1, 1'b0, 0);
        idle_cycles(3);
        do_read(12'h0AB, 8'h3C, 1'b1, 8);
        idle_cycles(40);

        for (int g = 0; g < 50 && q.size() > 0; g++) @(posedge clk);
        chk("scoreboard_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
